// File: rtl/uart_channel.sv
// uart_channel: one full-duplex 8N1 UART with 16x oversampled receiver,
// TX/RX FIFOs and a registered status word for the CPU register block.
module uart_channel #(
    parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] divider,
    input  logic        tx_wr,
    input  logic [7:0]  tx_data,
    input  logic        rx_rd,
    output logic [7:0]  rx_data,
    output logic [5:0]  status,
    input  logic        rxd,
    output logic        txd
);

    localparam int unsigned PW    = FIFO_DEPTH_LOG2;
    localparam int unsigned CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // ------------------------------------------------------------------
    // Oversample tick generator
    // ------------------------------------------------------------------
    logic [15:0] tick_cnt;
    logic [15:0] div_m1;
    logic        tick;

    // Wrap point; divider values 0 and 1 both give a tick every cycle.
    // Using >= lets a shrinking divider wrap on the very next cycle.
    always_comb begin
        div_m1 = (divider < 16'd2) ? 16'd0 : (divider - 16'd1);
        tick   = (tick_cnt >= div_m1);
    end

    // Free-running tick counter
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= 16'd0;
        end else if (tick) begin
            tick_cnt <= 16'd0;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    tx_mem [DEPTH];
    logic [PW-1:0] tx_wp;
    logic [PW-1:0] tx_rp;
    logic [CW-1:0] tx_cnt;
    logic          tx_empty;
    logic          tx_full;
    logic          tx_push;
    logic          tx_pop;
    logic [7:0]    tx_head;

    // FIFO flags and head byte
    always_comb begin
        tx_empty = (tx_cnt == CW'(0));
        tx_full  = (tx_cnt == CW'(DEPTH));
        tx_push  = tx_wr & ~tx_full;
        tx_head  = tx_mem[tx_rp];
    end

    // TX storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wp] <= tx_data;
        end
    end

    // TX pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + PW'(1);
            if (tx_pop)  tx_rp <= tx_rp + PW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + CW'(1);
                2'b01:   tx_cnt <= tx_cnt - CW'(1);
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    logic [1:0] tx_state, tx_state_n;
    logic [3:0] tx_tcnt,  tx_tcnt_n;
    logic [2:0] tx_bcnt,  tx_bcnt_n;
    logic [7:0] tx_shift, tx_shift_n;
    logic       txd_n;

    // TX state register
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= S_IDLE;
            tx_tcnt  <= 4'd0;
            tx_bcnt  <= 3'd0;
            tx_shift <= 8'd0;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_tcnt  <= tx_tcnt_n;
            tx_bcnt  <= tx_bcnt_n;
            tx_shift <= tx_shift_n;
            txd      <= txd_n;
        end
    end

    // TX next state; txd is registered so it changes with the state
    always_comb begin
        tx_state_n = tx_state;
        tx_tcnt_n  = tx_tcnt;
        tx_bcnt_n  = tx_bcnt;
        tx_shift_n = tx_shift;
        txd_n      = txd;
        tx_pop     = 1'b0;
        case (tx_state)
            S_IDLE: begin
                txd_n = 1'b1;
                if (tick && !tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = tx_head;
                    tx_tcnt_n  = 4'd0;
                    tx_state_n = S_START;
                    txd_n      = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (tx_tcnt == 4'd15) begin
                        tx_tcnt_n  = 4'd0;
                        tx_bcnt_n  = 3'd0;
                        tx_state_n = S_DATA;
                        txd_n      = tx_shift[0];
                    end else begin
                        tx_tcnt_n = tx_tcnt + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (tx_tcnt == 4'd15) begin
                        tx_tcnt_n = 4'd0;
                        if (tx_bcnt == 3'd7) begin
                            tx_state_n = S_STOP;
                            txd_n      = 1'b1;
                        end else begin
                            tx_bcnt_n  = tx_bcnt + 3'd1;
                            tx_shift_n = {1'b0, tx_shift[7:1]};
                            txd_n      = tx_shift[1];
                        end
                    end else begin
                        tx_tcnt_n = tx_tcnt + 4'd1;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (tx_tcnt == 4'd15) begin
                        tx_tcnt_n = 4'd0;
                        if (!tx_empty) begin
                            tx_pop     = 1'b1;
                            tx_shift_n = tx_head;
                            tx_state_n = S_START;
                            txd_n      = 1'b0;
                        end else begin
                            tx_state_n = S_IDLE;
                            txd_n      = 1'b1;
                        end
                    end else begin
                        tx_tcnt_n = tx_tcnt + 4'd1;
                    end
                end
            end
            default: begin
                tx_state_n = S_IDLE;
                txd_n      = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // RX synchronizer
    // ------------------------------------------------------------------
    logic rx_s1, rx_s2, rx_s3;
    logic rx_bit;

    // Two metastability stages plus one more stage feeding the FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rxd;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign rx_bit = rx_s3;

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    rx_mem [DEPTH];
    logic [PW-1:0] rx_wp;
    logic [PW-1:0] rx_rp;
    logic [CW-1:0] rx_cnt;
    logic          rx_empty;
    logic          rx_full;
    logic          rx_push;
    logic          rx_pop;

    // FIFO flags; a pop while empty is ignored
    always_comb begin
        rx_empty = (rx_cnt == CW'(0));
        rx_full  = (rx_cnt == CW'(DEPTH));
        rx_pop   = rx_rd & ~rx_empty;
    end

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    logic [1:0] rx_state, rx_state_n;
    logic [3:0] rx_tcnt,  rx_tcnt_n;
    logic [2:0] rx_bcnt,  rx_bcnt_n;
    logic [7:0] rx_shift, rx_shift_n;
    logic       set_ov;
    logic       set_fe;

    // RX state register; reset discards any partial byte
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= S_IDLE;
            rx_tcnt  <= 4'd0;
            rx_bcnt  <= 3'd0;
            rx_shift <= 8'd0;
        end else begin
            rx_state <= rx_state_n;
            rx_tcnt  <= rx_tcnt_n;
            rx_bcnt  <= rx_bcnt_n;
            rx_shift <= rx_shift_n;
        end
    end

    // RX next state: start qualified at tick 7, data/stop sampled mid-bit
    always_comb begin
        rx_state_n = rx_state;
        rx_tcnt_n  = rx_tcnt;
        rx_bcnt_n  = rx_bcnt;
        rx_shift_n = rx_shift;
        rx_push    = 1'b0;
        set_ov     = 1'b0;
        set_fe     = 1'b0;
        case (rx_state)
            S_IDLE: begin
                if (tick && !rx_bit) begin
                    rx_tcnt_n  = 4'd0;
                    rx_state_n = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (rx_tcnt == 4'd7) begin
                        rx_tcnt_n = 4'd0;
                        rx_bcnt_n = 3'd0;
                        rx_state_n = rx_bit ? S_IDLE : S_DATA;
                    end else begin
                        rx_tcnt_n = rx_tcnt + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (rx_tcnt == 4'd15) begin
                        rx_tcnt_n  = 4'd0;
                        rx_shift_n = {rx_bit, rx_shift[7:1]};
                        if (rx_bcnt == 3'd7) begin
                            rx_state_n = S_STOP;
                        end else begin
                            rx_bcnt_n = rx_bcnt + 3'd1;
                        end
                    end else begin
                        rx_tcnt_n = rx_tcnt + 4'd1;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (rx_tcnt == 4'd15) begin
                        rx_tcnt_n  = 4'd0;
                        rx_state_n = S_IDLE;
                        if (!rx_bit) begin
                            set_fe = 1'b1;
                        end else if (rx_full) begin
                            set_ov = 1'b1;
                        end else begin
                            rx_push = 1'b1;
                        end
                    end else begin
                        rx_tcnt_n = rx_tcnt + 4'd1;
                    end
                end
            end
            default: begin
                rx_state_n = S_IDLE;
            end
        endcase
    end

    // RX storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wp] <= rx_shift;
        end
    end

    // RX pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + PW'(1);
            if (rx_pop)  rx_rp <= rx_rp + PW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + CW'(1);
                2'b01:   rx_cnt <= rx_cnt - CW'(1);
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register-interface outputs
    // ------------------------------------------------------------------
    logic [5:0] status_n;

    // Sticky flags clear on rx_rd, but a same-cycle set wins
    always_comb begin
        status_n[0] = ~rx_empty;
        status_n[1] = rx_full;
        status_n[2] = tx_empty & (tx_state == S_IDLE);
        status_n[3] = tx_full;
        status_n[4] = set_ov | (status[4] & ~rx_rd);
        status_n[5] = set_fe | (status[5] & ~rx_rd);
    end

    // Registered status word and show-ahead RX head
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data <= 8'd0;
            status  <= 6'b000100;
        end else begin
            rx_data <= rx_empty ? 8'd0 : rx_mem[rx_rp];
            status  <= status_n;
        end
    end

endmodule

// File: tb/tb_uart_channel.sv
// Directed testbench for uart_channel: reset, single TX frame, loopback
// burst, overrun, framing/false start, divider change and TX-full drop.
module tb_uart_channel;

    logic        clk;
    logic        reset;
    logic [15:0] divider;
    logic        tx_wr;
    logic [7:0]  tx_data;
    logic        rx_rd;
    logic [7:0]  rx_data;
    logic [5:0]  status;
    logic        rxd;
    logic        txd;
    logic        loop;
    logic        rxd_drv;

    int tests_run;
    int tests_failed;

    assign rxd = loop ? txd : rxd_drv;

    uart_channel #(.FIFO_DEPTH_LOG2(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .divider (divider),
        .tx_wr   (tx_wr),
        .tx_data (tx_data),
        .rx_rd   (rx_rd),
        .rx_data (rx_data),
        .status  (status),
        .rxd     (rxd),
        .txd     (txd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-cycle tx_wr strobe
    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        tx_wr   = 1'b1;
        tx_data = b;
        @(negedge clk);
        tx_wr   = 1'b0;
    endtask

    // One-cycle rx_rd strobe, then let rx_data/status settle
    task automatic pop_byte();
        @(negedge clk);
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Drive one 8N1 frame on rxd at 64 clocks per bit (divider = 4)
    task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
        rxd_drv = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            repeat (64) @(negedge clk);
        end
        rxd_drv = stop_bit;
        repeat (64) @(negedge clk);
        rxd_drv = 1'b1;
    endtask

    // Bounded wait for txd to go low
    task automatic wait_txd_low(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (txd === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (txd !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_txd: got %b expected 1", txd);
        end
        tests_run++;
        if (status !== 6'h04) begin
            tests_failed++;
            $display("FAIL reset_status: got %h expected 04", status);
        end
        tests_run++;
        if (rx_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_rx_data: got %h expected 00", rx_data);
        end
    endtask

    task automatic test_single_tx();
        logic [9:0] exp_bits;
        bit ok;
        exp_bits = {1'b1, 8'hA5, 1'b0};
        loop    = 1'b0;
        rxd_drv = 1'b1;
        divider = 16'd4;
        push_byte(8'hA5);
        wait_txd_low(200, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL tx_start_timeout: got txd=%b expected 0 within 200 cycles", txd);
            return;
        end
        repeat (31) @(negedge clk);
        tests_run++;
        if (status[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL tx_idle_during_frame: got %b expected 0", status[2]);
        end
        for (int k = 0; k < 10; k++) begin
            if (k != 0) repeat (64) @(negedge clk);
            tests_run++;
            if (txd !== exp_bits[k]) begin
                tests_failed++;
                $display("FAIL tx_bit%0d: got %b expected %b", k, txd, exp_bits[k]);
            end
        end
        repeat (35) @(negedge clk);
        tests_run++;
        if (status[2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL tx_idle_after_stop: got %b expected 1", status[2]);
        end
    endtask

    task automatic test_loopback();
        bit ok;
        int cnt;
        loop    = 1'b1;
        divider = 16'hFFFF;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        repeat (2) @(negedge clk);
        tests_run++;
        if (status[3] !== 1'b1) begin
            tests_failed++;
            $display("FAIL tx_full_after_16: got %b expected 1", status[3]);
        end
        tests_run++;
        if (status[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL tx_idle_with_data: got %b expected 0", status[2]);
        end
        push_byte(8'hEE);
        repeat (2) @(negedge clk);
        tests_run++;
        if (status[3] !== 1'b1) begin
            tests_failed++;
            $display("FAIL tx_full_after_17: got %b expected 1", status[3]);
        end
        divider = 16'd4;
        wait_txd_low(100, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL burst_start_timeout: got txd=%b expected 0 within 100 cycles", txd);
            return;
        end
        cnt = 0;
        while (status[2] !== 1'b1 && cnt < 11000) begin
            @(negedge clk);
            cnt++;
        end
        tests_run++;
        if (cnt < 10240 || cnt > 10243) begin
            tests_failed++;
            $display("FAIL burst_duration: got %0d cycles expected 10240..10243", cnt);
        end
        repeat (10) @(negedge clk);
        tests_run++;
        if (status !== 6'b000111) begin
            tests_failed++;
            $display("FAIL burst_status: got %b expected 000111", status);
        end
        tests_run++;
        if (rx_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL burst_head: got %h expected 00", rx_data);
        end
    endtask

    task automatic test_overrun();
        push_byte(8'h55);
        repeat (720) @(negedge clk);
        tests_run++;
        if (status[4] !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_set: got %b expected 1", status[4]);
        end
        tests_run++;
        if (rx_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL overrun_head: got %h expected 00", rx_data);
        end
        pop_byte();
        tests_run++;
        if (status[4] !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_clear: got %b expected 0", status[4]);
        end
        for (int i = 1; i < 16; i++) begin
            tests_run++;
            if (rx_data !== 8'(i)) begin
                tests_failed++;
                $display("FAIL rx_order_%0d: got %h expected %h", i, rx_data, 8'(i));
            end
            pop_byte();
        end
        tests_run++;
        if (status[1:0] !== 2'b00) begin
            tests_failed++;
            $display("FAIL rx_drained: got %b expected 00", status[1:0]);
        end
    endtask

    task automatic test_framing();
        loop    = 1'b0;
        rxd_drv = 1'b1;
        divider = 16'd4;
        repeat (20) @(negedge clk);
        drive_frame(8'h3C, 1'b0);
        repeat (100) @(negedge clk);
        tests_run++;
        if (status[5] !== 1'b1 || status[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL frame_err: got fe=%b avail=%b expected fe=1 avail=0", status[5], status[0]);
        end
        pop_byte();
        tests_run++;
        if (status[5] !== 1'b0) begin
            tests_failed++;
            $display("FAIL frame_err_clear: got %b expected 0", status[5]);
        end
        rxd_drv = 1'b0;
        repeat (12) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (200) @(negedge clk);
        tests_run++;
        if (status[0] !== 1'b0 || status[5] !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch: got avail=%b fe=%b expected 0 0", status[0], status[5]);
        end
        drive_frame(8'hC3, 1'b1);
        repeat (20) @(negedge clk);
        tests_run++;
        if (status[0] !== 1'b1 || rx_data !== 8'hC3) begin
            tests_failed++;
            $display("FAIL after_glitch_rx: got avail=%b data=%h expected 1 c3", status[0], rx_data);
        end
        pop_byte();
    endtask

    task automatic test_divider();
        bit ok;
        int cnt;
        loop    = 1'b0;
        rxd_drv = 1'b1;
        divider = 16'd27;
        repeat (60) @(negedge clk);
        divider = 16'd4;
        push_byte(8'h01);
        wait_txd_low(200, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL div_start_timeout: got txd=%b expected 0 within 200 cycles", txd);
            return;
        end
        cnt = 0;
        while (txd === 1'b0 && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        tests_run++;
        if (cnt != 64) begin
            tests_failed++;
            $display("FAIL div_bit_time: got %0d cycles expected 64", cnt);
        end
        repeat (700) @(negedge clk);
        tests_run++;
        if (status[2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL div_tx_idle: got %b expected 1", status[2]);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset   = 1'b1;
        divider = 16'd4;
        tx_wr   = 1'b0;
        tx_data = 8'h00;
        rx_rd   = 1'b0;
        loop    = 1'b0;
        rxd_drv = 1'b1;
        test_reset();
        test_single_tx();
        test_loopback();
        test_overrun();
        test_framing();
        test_divider();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
